// File: rtl/seg_counter_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_counter_scan
// Purpose  : N-digit up/down counter (decimal or hex digits) advanced by a
//            tick generator with four selectable periods, displayed on a
//            time-multiplexed common-anode 7-segment display.
// Ports    : clk   - system clock
//            rst   - asynchronous active-high reset
//            sel   - tick period select (RATE0..RATE3)
//            en    - 1 = count, 0 = hold divider and value
//            up    - count direction, sampled on the tick edge
//            clr   - synchronous clear of count and divider
//            value - packed BCD/hex digits, digit 0 in [3:0]
//            tick  - one-cycle pulse aligned with the updated value
//            wrap  - one-cycle pulse when the whole count wraps
//            seg   - segments {a,b,c,d,e,f,g}, active-low
//            an    - digit enables, active-low, one-hot-low
// Revision : 1.0 - initial release
// ============================================================================
module seg_counter_scan #(
    parameter int DIGITS   = 4,
    parameter int HEX      = 0,
    parameter int RATE0    = 25000000,
    parameter int RATE1    = 50000000,
    parameter int RATE2    = 100000000,
    parameter int RATE3    = 300000000,
    parameter int DIV_W    = 29,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            sel,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   value,
    output logic                  tick,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0]  c_P0_M1   = DIV_W'(RATE0 - 1);
    localparam logic [DIV_W-1:0]  c_P1_M1   = DIV_W'(RATE1 - 1);
    localparam logic [DIV_W-1:0]  c_P2_M1   = DIV_W'(RATE2 - 1);
    localparam logic [DIV_W-1:0]  c_P3_M1   = DIV_W'(RATE3 - 1);
    localparam logic [SCAN_W-1:0] c_SCAN_M1 = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  c_IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [3:0]        c_DMAX    = (HEX != 0) ? 4'd15 : 4'd9;

    // ------------------------------------------------------------------
    // Segment decoder, active-low {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]    r_div;
    logic [4*DIGITS-1:0] r_value;
    logic                r_tick;
    logic                r_wrap;
    logic [SCAN_W-1:0]   r_scan;
    logic [IDX_W-1:0]    r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic [DIV_W-1:0]    w_period_m1;
    logic [4*DIGITS-1:0] w_next;
    logic                w_carry;
    logic [3:0]          w_digit;

    assign value = r_value;
    assign tick  = r_tick;
    assign wrap  = r_wrap;
    assign seg   = r_seg;
    assign an    = r_an;

    // Period is re-selected every cycle; the divider compares with >= so a
    // shorter period chosen mid-count fires on the very next edge.
    always_comb begin
        case (sel)
            2'd0:    w_period_m1 = c_P0_M1;
            2'd1:    w_period_m1 = c_P1_M1;
            2'd2:    w_period_m1 = c_P2_M1;
            default: w_period_m1 = c_P3_M1;
        endcase
    end

    // Ripple carry/borrow across digits. A carry that survives past the top
    // digit means every digit rolled over, i.e. the whole count wrapped.
    always_comb begin
        w_next  = r_value;
        w_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (up) begin
                    if (r_value[i*4 +: 4] == c_DMAX) begin
                        w_next[i*4 +: 4] = 4'd0;
                    end else begin
                        w_next[i*4 +: 4] = r_value[i*4 +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_value[i*4 +: 4] == 4'd0) begin
                        w_next[i*4 +: 4] = c_DMAX;
                    end else begin
                        w_next[i*4 +: 4] = r_value[i*4 +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_value <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (clr) begin
            r_div   <= '0;
            r_value <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (r_div >= w_period_m1) begin
                r_div   <= '0;
                r_value <= w_next;
                r_tick  <= 1'b1;
                r_wrap  <= w_carry;
            end else begin
                r_div   <= r_div + 1'b1;
                r_tick  <= 1'b0;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display scan: free-running, unaffected by en/clr
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == c_SCAN_M1) begin
            r_scan <= '0;
            r_idx  <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_value[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 7'b1111111;
            r_an  <= '1;
        end else begin
            r_seg <= f_decode(w_digit);
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

endmodule
`default_nettype wire
